// File: rtl/yuv2rgb_pkg.sv
// Shared constants and types for the YUV 4:2:2 to RGB888 converter.
package yuv2rgb_pkg;

  localparam int unsigned CH_W   = 8;
  localparam int unsigned RGB_W  = 3 * CH_W;
  localparam int unsigned FRAC_W = 12;
  localparam int          ROUND_K = 2048;

  localparam int COEF_RV = 5743;
  localparam int COEF_GU = 1409;
  localparam int COEF_GV = 2925;
  localparam int COEF_BU = 7258;

  // Product headroom: |7258*128|+2048 < 2^20; chroma terms fit in +/-227.
  localparam int unsigned PROD_W = 24;
  localparam int unsigned T_W    = 10;
  localparam int unsigned SUM_W  = 12;

  typedef enum logic [1:0] {
    S_U  = 2'd0,
    S_Y0 = 2'd1,
    S_V  = 2'd2,
    S_Y1 = 2'd3
  } state_t;

endpackage

// File: rtl/yuv2rgb_if.sv
// Byte-stream input and pixel output bundle of the converter.
interface yuv2rgb_if;
  import yuv2rgb_pkg::*;

  logic             in_en;
  logic [CH_W-1:0]  yuv_in;
  logic             busy;
  logic             out_valid;
  logic [RGB_W-1:0] rgb_out;

  modport master (output in_en, yuv_in, input busy, out_valid, rgb_out);
  modport slave  (input in_en, yuv_in, output busy, out_valid, rgb_out);

endinterface

// File: rtl/yuv2rgb_clip.sv
// Saturates a signed channel sum into the unsigned 0..255 range.
module yuv2rgb_clip
  import yuv2rgb_pkg::*;
(
  input  logic signed [SUM_W-1:0] sum,
  output logic        [CH_W-1:0]  ch_c
);

  localparam logic signed [SUM_W-1:0] CH_MAX = SUM_W'((1 << CH_W) - 1);

  always_comb begin
    ch_c = sum[CH_W-1:0];
    if (sum[SUM_W-1]) begin
      ch_c = '0;
    end else if (sum > CH_MAX) begin
      ch_c = '1;
    end
  end

endmodule

// File: rtl/yuv2rgb_conv.sv
// Converts a U,Y0,V,Y1 byte stream into two RGB888 pixels per pair,
// through a chroma/luma stage and a clip/output stage.
module yuv2rgb_conv
  import yuv2rgb_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  yuv2rgb_if.slave  bus
);

  state_t state_q, state_d;
  logic   accept;
  logic   busy_q;

  logic [CH_W-1:0] u_q, y_q, v_q;
  logic            pend_q, pend_chroma_q;

  logic                  s1_valid_q;
  logic [CH_W-1:0]       s1_y_q;
  logic signed [T_W-1:0] s1_tr_q, s1_tg_q, s1_tb_q;

  logic             out_valid_q;
  logic [RGB_W-1:0] rgb_q;

  logic signed [PROD_W-1:0] u_ext, v_ext;
  logic signed [T_W-1:0]    tr_c, tg_c, tb_c;
  logic signed [SUM_W-1:0]  y_ext, sum_r, sum_g, sum_b;
  logic [CH_W-1:0]          r_c, g_c, b_c;

  // Input byte sequencer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_U;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = bus.in_en & ~busy_q;
    if (accept) begin
      case (state_q)
        S_U:     state_d = S_Y0;
        S_Y0:    state_d = S_V;
        S_V:     state_d = S_Y1;
        default: state_d = S_U;
      endcase
    end
  end

  // Chroma terms from the stored U/V; Q12 with round-half-up
  assign u_ext = PROD_W'($signed(u_q));
  assign v_ext = PROD_W'($signed(v_q));
  assign tr_c  = T_W'((v_ext * PROD_W'(COEF_RV) + PROD_W'(ROUND_K)) >>> FRAC_W);
  assign tg_c  = T_W'((PROD_W'(ROUND_K) - u_ext * PROD_W'(COEF_GU)
                       - v_ext * PROD_W'(COEF_GV)) >>> FRAC_W);
  assign tb_c  = T_W'((u_ext * PROD_W'(COEF_BU) + PROD_W'(ROUND_K)) >>> FRAC_W);

  assign y_ext = $signed(SUM_W'(s1_y_q));
  assign sum_r = y_ext + SUM_W'(s1_tr_q);
  assign sum_g = y_ext + SUM_W'(s1_tg_q);
  assign sum_b = y_ext + SUM_W'(s1_tb_q);

  yuv2rgb_clip u_clip_r (.sum(sum_r), .ch_c(r_c));
  yuv2rgb_clip u_clip_g (.sum(sum_g), .ch_c(g_c));
  yuv2rgb_clip u_clip_b (.sum(sum_b), .ch_c(b_c));

  // Byte capture, stage 1 (chroma + luma) and stage 2 (clipped pixel)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q        <= 1'b1;
      u_q           <= '0;
      y_q           <= '0;
      v_q           <= '0;
      pend_q        <= 1'b0;
      pend_chroma_q <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_y_q        <= '0;
      s1_tr_q       <= '0;
      s1_tg_q       <= '0;
      s1_tb_q       <= '0;
      out_valid_q   <= 1'b0;
      rgb_q         <= '0;
    end else begin
      busy_q        <= 1'b0;
      pend_q        <= accept && (state_q == S_V || state_q == S_Y1);
      pend_chroma_q <= accept && (state_q == S_V);
      if (accept) begin
        case (state_q)
          S_U:     u_q <= bus.yuv_in;
          S_V:     v_q <= bus.yuv_in;
          default: y_q <= bus.yuv_in;
        endcase
      end
      s1_valid_q <= pend_q;
      if (pend_q) s1_y_q <= y_q;
      // Chroma is latched once per pair and reused for the second pixel
      if (pend_chroma_q) begin
        s1_tr_q <= tr_c;
        s1_tg_q <= tg_c;
        s1_tb_q <= tb_c;
      end
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) rgb_q <= {r_c, g_c, b_c};
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.rgb_out   = rgb_q;

endmodule

// File: tb/tb_yuv2rgb_conv.sv
// Self-checking bench for yuv2rgb_conv: directed pairs, reset cases, random stream.
module tb_yuv2rgb_conv;

  typedef struct {
    logic [23:0] rgb;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   pulses = 0;
  logic [23:0] last_rgb = '0;
  exp_t exp_q[$];
  exp_t mon_e;

  yuv2rgb_if bus ();

  yuv2rgb_conv dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] clamp(input int x);
    if (x < 0) return 8'h00;
    if (x > 255) return 8'hFF;
    return 8'(x);
  endfunction

  // Reference: plain integer BT.601-style conversion in Q12 with floor shift
  function automatic logic [23:0] ref_pixel(input logic [7:0] ub, input logic [7:0] yb,
                                            input logic [7:0] vb);
    int u, v, y, tr, tg, tb;
    u  = int'($signed(ub));
    v  = int'($signed(vb));
    y  = int'(yb);
    tr = (5743 * v + 2048) >>> 12;
    tg = (-1409 * u - 2925 * v + 2048) >>> 12;
    tb = (7258 * u + 2048) >>> 12;
    return {clamp(y + tr), clamp(y + tg), clamp(y + tb)};
  endfunction

  // Output monitor: every pulse must match the next expected pixel and its cycle
  always @(negedge clk) begin
    if (reset) begin
      last_rgb = '0;
    end else if (bus.out_valid) begin
      pulses++;
      if (exp_q.size() == 0) begin
        check("stray_pulse", 32'(bus.out_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pixel_rgb", 32'(bus.rgb_out), 32'(mon_e.rgb));
        check("pixel_time", 32'(cyc), 32'(mon_e.due));
      end
      last_rgb = bus.rgb_out;
    end else begin
      check("rgb_hold", 32'(bus.rgb_out), 32'(last_rgb));
    end
  end

  // Called at posedge+1; returns the edge index at which the byte was taken
  task automatic send_byte(input logic [7:0] b, output int acc);
    int waited;
    waited     = 0;
    acc        = -1;
    bus.in_en  = 1'b1;
    bus.yuv_in = b;
    while (acc < 0 && waited < 50) begin
      @(negedge clk);
      if (!bus.busy) begin
        @(posedge clk);
        #1;
        acc = cyc;
      end else begin
        waited++;
      end
    end
    bus.in_en = 1'b0;
    if (acc < 0) check("accept_timeout", 32'(bus.busy), 32'd0);
  endtask

  task automatic push_exp(input logic [23:0] rgb, input int due);
    exp_t ent;
    ent.rgb = rgb;
    ent.due = due;
    exp_q.push_back(ent);
  endtask

  task automatic send_pair(input logic [7:0] u, input logic [7:0] y0, input logic [7:0] v,
                           input logic [7:0] y1, input int gap, input bit use_exp,
                           input logic [23:0] e0, input logic [23:0] e1);
    logic [7:0] bs [4];
    int acc, prev;
    bs   = '{u, y0, v, y1};
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      send_byte(bs[i], acc);
      if (i == 2) push_exp(use_exp ? e0 : ref_pixel(u, y0, v), acc + 2);
      if (i == 3) push_exp(use_exp ? e1 : ref_pixel(u, y1, v), acc + 2);
      if (gap == 0 && i > 0) check("stream_accept", 32'(acc - prev), 32'd1);
      prev = acc;
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 20) begin
      @(posedge clk);
      w++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, p0, gap;
    logic [7:0] ru, ry0, rv, ry1;

    reset      = 1'b1;
    bus.in_en  = 1'b0;
    bus.yuv_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_rgb", 32'(bus.rgb_out), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("busy_after_rst", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("busy_clear", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;

    send_pair(8'h00, 8'h80, 8'h00, 8'h80, 0, 1'b1, 24'h808080, 24'h808080);
    send_pair(8'h00, 8'hFF, 8'h7F, 8'h00, 0, 1'b1, 24'hFFA4FF, 24'hB20000);
    send_pair(8'h80, 8'h80, 8'h00, 8'h80, 0, 1'b1, 24'h80AC00, 24'h80AC00);
    drain();
    send_pair(8'h00, 8'h80, 8'h00, 8'h80, 3, 1'b1, 24'h808080, 24'h808080);
    drain();

    // Reset after a partial pair (U,Y0 then U,Y0,V): nothing may emerge from it
    for (int n = 2; n <= 3; n++) begin
      send_byte(8'h11, acc);
      send_byte(8'h22, acc);
      if (n == 3) send_byte(8'h33, acc);
      reset = 1'b1;
      #1;
      check("midrst_busy", 32'(bus.busy), 32'd1);
      check("midrst_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_rgb", 32'(bus.rgb_out), 32'h0);
      repeat (3) @(posedge clk);
      #1;
      reset      = 1'b0;
      bus.in_en  = 1'b1;
      bus.yuv_in = 8'h55;
      @(negedge clk);
      check("rel_busy", 32'(bus.busy), 32'd1);
      @(posedge clk);
      #1;
      bus.in_en = 1'b0;
      check("rel_busy_one", 32'(bus.busy), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      send_pair(8'h00, 8'hFF, 8'h7F, 8'h00, 0, 1'b1, 24'hFFA4FF, 24'hB20000);
      drain();
    end

    p0 = pulses;
    for (int k = 0; k < 500; k++) begin
      ru  = 8'($urandom);
      ry0 = 8'($urandom);
      rv  = 8'($urandom);
      ry1 = 8'($urandom);
      gap = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      send_pair(ru, ry0, rv, ry1, gap, 1'b0, 24'h0, 24'h0);
    end
    drain();
    check("random_pulse_count", 32'(pulses - p0), 32'd1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
